// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, flags and an optional multi-cycle multiply.
// Define ALU_SEQ_MUL_EN to build opcode 111 as a WIDTH-cycle shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic             accept_s;
  logic [SW-1:0]    shamt_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   shr_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic             load_s;
  logic [WIDTH-1:0] ld_y_s;
  logic             ld_c_s;
  logic             ld_v_s;

  assign accept_s = in_valid && in_ready;
  assign shamt_s  = b[SW-1:0];

  // Extra bit on each side of the shifts captures the last bit shifted out.
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};
  assign shl_s = {1'b0, a} << shamt_s;
  assign shr_s = {a, 1'b0} >> shamt_s;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  state_t             state_r;
  logic [SW-1:0]      cnt_r;
  logic [WIDTH-1:0]   ma_r;
  logic [WIDTH-1:0]   mb_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] pp_s;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic               start_mul_s;
  logic               mul_done_s;

  assign in_ready    = (state_r == ST_IDLE) && (!out_valid || out_ready);
  assign start_mul_s = accept_s && (ctrl == OP_MUL);
  assign mul_done_s  = (state_r == ST_MUL) && (cnt_r == CNT_LAST);
  assign pp_s        = {{WIDTH{1'b0}}, ma_r} << cnt_r;
  assign acc_nxt_s   = acc_r + (mb_r[cnt_r] ? pp_s : {(2*WIDTH){1'b0}});
`else
  assign in_ready = !out_valid || out_ready;
`endif

  // Single-cycle datapath: result, carry and overflow for every opcode.
  always_comb begin
    alu_y_s = {WIDTH{1'b0}};
    alu_c_s = 1'b0;
    alu_v_s = 1'b0;
    case (ctrl)
      OP_AND: alu_y_s = a & b;
      OP_OR:  alu_y_s = a | b;
      OP_XOR: alu_y_s = a ^ b;
      OP_ADD: begin
        alu_y_s = add_s[WIDTH-1:0];
        alu_c_s = add_s[WIDTH];
        alu_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y_s = sub_s[WIDTH-1:0];
        alu_c_s = sub_s[WIDTH];
        alu_v_s = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        alu_y_s = shl_s[WIDTH-1:0];
        alu_c_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        alu_y_s = shr_s[WIDTH:1];
        alu_c_s = shr_s[0];
      end
      OP_MUL:  alu_y_s = {WIDTH{1'b0}};
      default: alu_y_s = {WIDTH{1'b0}};
    endcase
  end

  // Selects what, if anything, lands in the output registers this cycle.
  always_comb begin
    load_s = 1'b0;
    ld_y_s = alu_y_s;
    ld_c_s = alu_c_s;
    ld_v_s = alu_v_s;
`ifdef ALU_SEQ_MUL_EN
    if (mul_done_s) begin
      load_s = 1'b1;
      ld_y_s = acc_nxt_s[WIDTH-1:0];
      ld_c_s = |acc_nxt_s[2*WIDTH-1:WIDTH];
      ld_v_s = 1'b0;
    end else begin
      load_s = accept_s && (ctrl != OP_MUL);
    end
`else
    load_s = accept_s;
`endif
  end

  // Output registers hold steady until a new result loads; consume clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      y         <= ld_y_s;
      zero      <= (ld_y_s == {WIDTH{1'b0}});
      negative  <= ld_y_s[WIDTH-1];
      carry     <= ld_c_s;
      overflow  <= ld_v_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiply sequencer: one partial product per cycle into a double-width accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {SW{1'b0}};
      ma_r    <= {WIDTH{1'b0}};
      mb_r    <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_mul_s) begin
            ma_r    <= a;
            mb_r    <= b;
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {SW{1'b0}};
            state_r <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc_r <= acc_nxt_s;
          if (mul_done_s) begin
            cnt_r   <= {SW{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + {{(SW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt_r   <= {SW{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); multiply checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       negative;
  logic       carry;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] ey;
    logic [3:0] ef;  // {zero, negative, carry, overflow}
  } vec_t;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    ctrl = op;
    a = va;
    b = vb;
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    logic [12:0] got;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    ctrl = 3'b000;
    repeat (3) @(negedge clk);
    got = {out_valid, y, zero, negative, carry, overflow};
    checks++;
    if (got !== 13'h0000) $display("FAIL reset_state got=%h exp=%h", got, 13'h0000);
    if (got !== 13'h0000) errors++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  // Every opcode class issued back to back with in_valid held high.
  task automatic test_ops;
    vec_t vecs[12];
    logic [12:0] got;
    logic [12:0] exp;
    vecs[0]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 4'b1010};
    vecs[1]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 4'b0101};
    vecs[2]  = '{3'b110, 8'h05, 8'h07, 8'hFE, 4'b0110};
    vecs[3]  = '{3'b110, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[4]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[5]  = '{3'b001, 8'hF0, 8'h0F, 8'hFF, 4'b0100};
    vecs[6]  = '{3'b011, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    vecs[7]  = '{3'b100, 8'h81, 8'h01, 8'h02, 4'b0010};
    vecs[8]  = '{3'b101, 8'h81, 8'h03, 8'h10, 4'b0000};
    vecs[9]  = '{3'b100, 8'h81, 8'h08, 8'h81, 4'b0100};
    vecs[10] = '{3'b101, 8'h81, 8'h08, 8'h81, 4'b0100};
    vecs[11] = '{3'b100, 8'h03, 8'h07, 8'h80, 4'b0110};
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].va, vecs[i].vb);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL op%0d_in_ready got=%b exp=1", i, in_ready);
      end
      @(negedge clk);
      got = {out_valid, y, zero, negative, carry, overflow};
      exp = {1'b1, vecs[i].ey, vecs[i].ef};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL op%0d got v/y/znco=%b/%h/%b exp=%b/%h/%b", i,
                 got[12], got[11:4], got[3:0], exp[12], exp[11:4], exp[3:0]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [12:0] got;
    out_ready = 1'b0;
    drive(3'b010, 8'h02, 8'h03);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = {out_valid, y, zero, negative, carry, overflow};
      checks++;
      if (got !== {1'b1, 8'h05, 4'b0000} || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d got=%h in_ready=%b exp=%h in_ready=0", k, got,
                 in_ready, {1'b1, 8'h05, 4'b0000});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive(3'b000, 8'h0F, 8'h3C);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL swap_accept in_ready=%b out_valid=%b exp=1/1", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    got = {out_valid, y, zero, negative, carry, overflow};
    checks++;
    if (got !== {1'b1, 8'h0C, 4'b0000}) begin
      errors++;
      $display("FAIL swap_result got=%h exp=%h", got, {1'b1, 8'h0C, 4'b0000});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume_clear got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_mul;
    logic [11:0] got;
    int lat;
`ifdef ALU_SEQ_MUL_EN
    drive(3'b111, 8'h0C, 8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy in_ready=%b exp=0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL mul_latency got=%0d exp=8", lat);
    end
    got = {y, zero, negative, carry, overflow};
    checks++;
    if (got !== {8'h84, 4'b0100}) begin
      errors++;
      $display("FAIL mul_0c_0b got=%h exp=%h", got, {8'h84, 4'b0100});
    end
    drive(3'b111, 8'h10, 8'h10);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {y, zero, negative, carry, overflow};
    checks++;
    if (got !== {8'h00, 4'b1010} || lat != 8) begin
      errors++;
      $display("FAIL mul_10_10 got=%h lat=%0d exp=%h lat=8", got, lat, {8'h00, 4'b1010});
    end
`else
    drive(3'b001, 8'h5A, 8'h00);
    @(negedge clk);
    drive(3'b111, 8'h0C, 8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    got = {y, zero, negative, carry, overflow};
    checks++;
    if (got !== {8'h00, 4'b1000} || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL op7_off got=%h v=%b lat=%0d exp=%h v=1", got, out_valid, lat,
               {8'h00, 4'b1000});
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [12:0] got;
    drive(3'b001, 8'hF0, 8'h0F);
    @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
    drive(3'b111, 8'h0C, 8'h0B);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
`else
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    got = {out_valid, y, zero, negative, carry, overflow};
    checks++;
    if (got !== 13'h0000) begin
      errors++;
      $display("FAIL abort_clear got=%h exp=%h", got, 13'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_ready got=%b exp=1", in_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_lost got=%b exp=0", out_valid);
    end
    drive(3'b010, 8'h02, 8'h03);
    @(negedge clk);
    in_valid = 1'b0;
    got = {out_valid, y, zero, negative, carry, overflow};
    checks++;
    if (got !== {1'b1, 8'h05, 4'b0000}) begin
      errors++;
      $display("FAIL post_abort_add got=%h exp=%h", got, {1'b1, 8'h05, 4'b0000});
    end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_backpressure;
    test_mul;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with valid/ready handshakes on input and output. It keeps the existing 3-bit opcode map (AND/OR/ADD/SUB) and adds XOR, logical shifts and an optional multi-cycle shift-add multiply. It also provides a signed-overflow flag. It sits between the datapath operand registers and the writeback stage, replacing the fixed 8-bit combinational ALU where backpressure or multiply is needed.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥ 4
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand/opcode present
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ctrl  input  3  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result
- y  output  WIDTH  result
- zero, negative, carry, overflow  output  1 each  flags

## Operation
- Opcodes:
  - 000: y = a & b
  - 001: y = a | b
  - 010: y = a + b
  - 011: y = a ^ b
  - 100: y = a << s
  - 101: y = a >> s (logical)
  - 110: y = a − b
  - 111: y = low WIDTH bits of a × b (unsigned)
- Shift amount: s = b[clog2(WIDTH)−1:0].
- Flag rules, all ops:
  - zero = (y == 0).
  - negative = y[WIDTH−1].
- carry:
  - ADD: carry-out.
  - SUB: borrow (a < b unsigned).
  - SHL: last bit shifted out (a[WIDTH−s]).
  - SHR: a[s−1].
  - Shifts with s = 0: carry = 0.
  - MUL: 1 if upper WIDTH product bits ≠ 0.
  - AND/OR/XOR: 0.
- overflow:
  - ADD: signed overflow (a, b same sign, y different).
  - SUB: signed overflow (a, b differ in sign, y sign ≠ a sign).
  - All other ops: 0.
- Handshake:
  - Operation is accepted when in_valid && in_ready.
  - Result is consumed when out_valid && out_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational and does not depend on in_valid.
- State machine:
  - IDLE: on accept of a non-MUL op, load y/flags, set out_valid. On accept of MUL, latch a, b into internal registers, clear the accumulator and counter, and go to MUL.
  - MUL: one shift-add iteration per cycle (2·WIDTH-bit accumulator), counter 0..WIDTH−1. On the iteration with counter = WIDTH−1, load y/flags, set out_valid, return to IDLE. Inputs a, b, ctrl are ignored while in MUL.
- out_valid is cleared on consume unless a new result loads the same cycle.
- y and flags hold stable while out_valid && !out_ready.

## Timing
- Reset:
  - state = IDLE, out_valid = 0, y = 0, all flags = 0, counter = 0.
  - in_ready = 1 once rst deasserts.
- Non-MUL latency: accepted at edge N, so out_valid = 1 and result visible after edge N.
- MUL latency: accepted at edge N, so out_valid = 1 after edge N+WIDTH (WIDTH = 8 → 8 cycles). in_ready = 0 from after edge N until out_valid rises and the result is consumed.
- Back-to-back: with out_ready held 1, a non-MUL op can be accepted every cycle (full throughput).
- Simultaneous consume and accept in the same cycle: the new result replaces the old, and out_valid stays 1.
- rst asserted mid-MUL aborts immediately. All outputs go to reset values, and the operation is lost (no partial result).
- Reset-to-reset: rst high for any duration yields identical state; no minimum pulse beyond one clk edge of deassertion.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 111 is the multi-cycle multiply as above.
- ALU_SEQ_MUL_EN undefined:
  - Multiplier datapath, accumulator, counter and MUL state are not built.
  - Opcode 111 behaves like a single-cycle op returning y = 0, zero = 1, negative = carry = overflow = 0, with 1-cycle latency.
- Shared: all other opcodes are identical in both builds.

## Test plan
- WIDTH=8, ADD a=0xFF b=0x01 → y=0x00, zero=1, carry=1, overflow=0, negative=0, out_valid one cycle after accept.
- SUB a=0x05 b=0x07 → y=0xFE, carry=1, negative=1, zero=0. SUB a=0x80 b=0x01 → y=0x7F, overflow=1, carry=0.
- SHL a=0x81 b=0x01 → y=0x02, carry=1. SHR a=0x81 b=0x03 → y=0x10, carry=0. Shift with b=0x08 (s=0) → y=a, carry=0.
- MUL (macro on) a=0x0C b=0x0B → y=0x84, negative=1, carry=0, out_valid exactly 8 cycles after accept. a=0x10 b=0x10 → y=0x00, zero=1, carry=1. Macro off: opcode 111 → y=0, zero=1 after 1 cycle.
- Backpressure: out_ready=0 after a result → y/flags stable, in_ready=0. Raise out_ready together with a new in_valid AND op → accepted the same cycle, new result next cycle, out_valid never drops.
- Assert rst 4 cycles into a MUL → out_valid=0, y=0, flags=0, in_ready=1 after release. A following ADD 0x02+0x03 → y=0x05.
